uart_tx_fifo: RTL and testbench

Buffered UART transmitter, 8N1, LSB first. It serialises bytes pushed through a valid/ready interface onto a single TX line. It is the return path from the CPU/user-interface logic to the host PC, which lets results, instruction words and flags be streamed out over the same serial link that loads programs. An internal FIFO decouples bursty producers from the baud-rate serialiser.

---
 rtl/uart_tx_fifo.sv | 151 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a byte FIFO feeds an LSB-first serialiser.
// The line is registered; consecutive frames go out with no idle gap while bytes are queued.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    i_tx_data,
  input  logic                          i_tx_valid,
  output logic                          o_tx_ready,
  output logic                          o_tx,
  output logic                          o_tx_busy,
  output logic                          o_tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;

  state_t        state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          tx, tx_n;
  logic          baud_last;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  // A full FIFO refuses the push even if the serialiser pops in the same cycle.
  assign push  = i_tx_valid && !full;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign baud_last = (baud == BAUD_LAST);

  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          baud_n  = '0;
          state_n = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_n    = '0;
          bit_idx_n = '0;
          state_n   = DATA;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
            shift_n   = {1'b0, shift[7:1]};
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_n = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level is decided from the next state so it registers together with it.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      tx      <= tx_n;
    end
  end

  assign o_tx         = tx;
  assign o_tx_busy    = (state != IDLE);
  assign o_tx_done    = (state == STOP) && baud_last;
  assign o_tx_ready   = !full;
  assign o_fifo_count = count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-level reference model, line decoder and directed corner cases.
module tb_uart_tx_fifo;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 125_000;
  localparam int C        = CLK_FREQ / BAUD;
  localparam int DEPTH    = 16;
  localparam int CW       = $clog2(DEPTH) + 1;
  localparam int FRAME    = 10 * C;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [7:0]    i_tx_data = 8'h00;
  logic          i_tx_valid = 1'b0;
  logic          o_tx_ready, o_tx, o_tx_busy, o_tx_done;
  logic [CW-1:0] o_fifo_count;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid),
    .o_tx_ready(o_tx_ready), .o_tx(o_tx), .o_tx_busy(o_tx_busy), .o_tx_done(o_tx_done),
    .o_fifo_count(o_fifo_count)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a queue of buffered bytes plus the number of cycles left in the current frame.
  logic [7:0] mq[$];
  logic [7:0] sent[$];
  logic [7:0] cur = 8'h00;
  int         rem = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      sent.delete();
      rem = 0;
    end else begin
      int sz;
      sz = mq.size();
      if (sz > 0 && rem <= 1) begin
        cur = mq.pop_front();
        sent.push_back(cur);
        rem = FRAME;
      end else if (rem > 0) begin
        rem--;
      end
      if (i_tx_valid && sz < DEPTH) mq.push_back(i_tx_data);
    end
  end

  function automatic logic exp_line();
    int b;
    if (rem == 0) return 1'b1;
    b = (FRAME - rem) / C;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur[b-1];
  endfunction

  int  cyc = 0, done_cnt = 0, busy_cyc = 0, fall_cnt = 0, last_fall = 0, fall_gap = 0;
  logic prev_tx = 1'b1;
  bit  rx_act = 1'b0;
  int  rx_c = 0, rx_cnt = 0;
  logic [9:0] rx_sh = '0;
  logic [7:0] rx_last = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_act  = 1'b0;
      prev_tx = 1'b1;
    end else begin
      cyc++;
      check("cycle {tx,busy,done,ready,count}",
            32'({o_tx, o_tx_busy, o_tx_done, o_tx_ready, o_fifo_count}),
            32'({exp_line(), rem > 0, rem == 1, mq.size() < DEPTH, CW'(mq.size())}));
      if (o_tx_done) done_cnt++;
      if (o_tx_busy) busy_cyc++;
      if (prev_tx && !o_tx) begin
        fall_cnt++;
        fall_gap  = cyc - last_fall;
        last_fall = cyc;
      end
      prev_tx = o_tx;
      // Independent line decoder sampling the middle of each bit.
      if (!rx_act) begin
        if (!o_tx) begin
          rx_act = 1'b1;
          rx_c   = 0;
        end
      end else begin
        rx_c++;
        if ((rx_c % C) == C / 2) begin
          rx_sh[rx_c / C] = o_tx;
          if (rx_c / C == 9) begin
            rx_act = 1'b0;
            check("rx framing {stop,start}", 32'({rx_sh[9], rx_sh[0]}), 32'(2'b10));
            check("rx frame expected", 32'(sent.size() > 0), 1);
            if (sent.size() > 0) check("rx byte", 32'(rx_sh[8:1]), 32'(sent.pop_front()));
            rx_last = rx_sh[8:1];
            rx_cnt++;
          end
        end
      end
    end
  end

  task automatic push1(input logic [7:0] d);
    i_tx_valid = 1'b1;
    i_tx_data  = d;
    @(posedge clk); #2;
    i_tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n;
    n = 0;
    while ((o_tx_busy || o_fifo_count != 0) && n < max) begin
      @(posedge clk); #2;
      n++;
    end
    check({name, " drained in time"}, 32'(n < max), 1);
  endtask

  task automatic wait_done(input string name, input int max);
    int n;
    n = 0;
    while (!o_tx_done && n < max) begin
      @(posedge clk); #2;
      n++;
    end
    check({name, " done seen"}, 32'(o_tx_done), 1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;   // line[0] is the start bit, line[9] the stop bit
  } vec_t;

  vec_t vecs[5];

  initial begin
    int d0, f0, b0, r0, idx, n;
    bit acc;

    vecs[0] = '{8'h41, 10'h282};
    vecs[1] = '{8'h00, 10'h200};
    vecs[2] = '{8'hFF, 10'h3FE};
    vecs[3] = '{8'hA5, 10'h34A};
    vecs[4] = '{8'h3C, 10'h278};

    #1 rst_n = 1'b0;
    #1;
    check("reset tx", 32'(o_tx), 1);
    check("reset busy", 32'(o_tx_busy), 0);
    check("reset done", 32'(o_tx_done), 0);
    check("reset ready", 32'(o_tx_ready), 1);
    check("reset count", 32'(o_fifo_count), 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // Single frames against hand-written line patterns.
    for (int i = 0; i < 5; i++) begin
      push1(vecs[i].data);
      check($sformatf("v%0d tx high on push edge", i), 32'(o_tx), 1);
      d0 = done_cnt;
      @(posedge clk); #2;
      check($sformatf("v%0d tx low one edge later", i), 32'(o_tx), 0);
      for (int b = 0; b < 10; b++) begin
        repeat (b == 0 ? C / 2 : C) @(posedge clk);
        #2;
        check($sformatf("v%0d line bit %0d", i, b), 32'(o_tx), 32'(vecs[i].line[b]));
      end
      repeat (C / 2) @(posedge clk);
      #2;
      check($sformatf("v%0d busy low after frame", i), 32'(o_tx_busy), 0);
      check($sformatf("v%0d one done pulse", i), 32'(done_cnt - d0), 1);
    end

    // Back-to-back frames.
    f0 = fall_cnt;
    i_tx_valid = 1'b1; i_tx_data = 8'h00;
    @(posedge clk); #2;
    i_tx_data = 8'hFF;
    @(posedge clk); #2;
    i_tx_valid = 1'b0;
    b0 = busy_cyc;
    d0 = done_cnt;
    wait_idle("b2b", 3 * FRAME);
    check("b2b start edges", 32'(fall_cnt - f0), 2);
    check("b2b start spacing", 32'(fall_gap), 32'(FRAME));
    check("b2b busy cycles", 32'(busy_cyc - b0), 32'(2 * FRAME));
    check("b2b done pulses", 32'(done_cnt - d0), 2);

    // Overfill: 18 offers on consecutive cycles, the last one lands on a full FIFO.
    r0 = rx_cnt;
    for (int i = 0; i < 18; i++) begin
      i_tx_valid = 1'b1;
      i_tx_data  = 8'(i);
      @(posedge clk); #2;
    end
    i_tx_valid = 1'b0;
    check("full count", 32'(o_fifo_count), 16);
    check("full ready", 32'(o_tx_ready), 0);
    wait_idle("full", 18 * FRAME);
    check("full frames sent", 32'(rx_cnt - r0), 17);
    check("full last byte", 32'(rx_last), 32'h10);

    // Push on the cycle the serialiser pops, with 15 bytes buffered.
    r0 = rx_cnt;
    for (int i = 0; i < 16; i++) push1(8'(8'h80 + i));
    check("fill to 15", 32'(o_fifo_count), 15);
    wait_done("pp", FRAME + 10);
    push1(8'hEE);
    check("push+pop count", 32'(o_fifo_count), 15);
    check("push+pop busy", 32'(o_tx_busy), 1);
    wait_idle("pp", 18 * FRAME);
    check("push+pop frames", 32'(rx_cnt - r0), 17);
    check("push+pop last byte", 32'(rx_last), 32'hEE);

    // Reset in the middle of the second of three frames.
    push1(8'h11); push1(8'h22); push1(8'h33);
    wait_done("rst", FRAME + 10);
    repeat (3 * C) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid rst tx", 32'(o_tx), 1);
    check("mid rst count", 32'(o_fifo_count), 0);
    check("mid rst busy", 32'(o_tx_busy), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    f0 = fall_cnt;
    repeat (10000) @(posedge clk);
    #2;
    check("post rst no frame", 32'(fall_cnt - f0), 0);
    check("post rst line idle", 32'(o_tx), 1);
    r0 = rx_cnt;
    push1(8'hA5);
    wait_idle("post rst", FRAME + 10);
    check("post rst frames", 32'(rx_cnt - r0), 1);
    check("post rst byte", 32'(rx_last), 32'hA5);

    // Random-valid stream of 0x00..0xFF; data is scrambled on idle cycles.
    r0 = rx_cnt; idx = 0; n = 0;
    while (idx < 256 && n < 40000) begin
      i_tx_valid = ($urandom_range(0, 3) != 0);
      i_tx_data  = i_tx_valid ? 8'(idx) : 8'($urandom);
      acc = i_tx_valid && o_tx_ready;
      @(posedge clk); #2;
      if (acc) idx++;
      n++;
    end
    i_tx_valid = 1'b0;
    check("stream all offered", 32'(idx), 256);
    wait_idle("stream", (DEPTH + 2) * FRAME);
    check("stream frames", 32'(rx_cnt - r0), 256);
    check("stream last byte", 32'(rx_last), 32'hFF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
